mem_rw_mux_sync: RTL and testbench
==================================

# mem_rw_mux_sync

Clocked, parametrised successor of the dual-rail memory read/write select stage. Accepts CH dual-rail channels of phase (ph0) and memory-instruction (mi) tokens under a four-phase DATA/NULL handshake, and computes one dual-rail RW decision per channel. Decisions are buffered in a DEPTH-entry FIFO and presented downstream under the same four-phase protocol. Adds illegal-code detection and a fill count. Sits between the instruction-decode dual-rail domain and the memory port controller.

## Interface
Parameters:
- CH, 4, number of dual-rail channels (≥1)
- DEPTH, 4, FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ph0  in  2*CH  dual-rail phase; pair i = ph0[2i+1] (true rail), ph0[2i] (false rail)
- mi  in  2*CH  dual-rail memory instruction, same packing
- ack  out  1  to upstream: 1 = current DATA wavefront accepted, return to NULL; 0 = ready for DATA
- rw  out  2*CH  dual-rail RW decision, same packing; true rail = write, false rail = read
- ack_in  in  1  from downstream: 1 = current rw DATA captured; 0 = ready for next
- err  out  1  sticky: illegal code 11 seen on any input pair
- count  out  $clog2(DEPTH+1)  FIFO occupancy

## Operation
- Pair codes: 00 NULL, 01 false, 10 true, 11 illegal.
- Input complete-DATA: every pair of ph0 and mi is 01 or 10. Input complete-NULL: all 4*CH rails 0. Any other mix is partial; wait.
- Per-channel function: rw_i = write (10) iff ph0_i true and mi_i true; otherwise read (01).
- FIFO stores one single-rail bit per channel (1 = write), CH bits per entry. Dual-rail re-encoding happens at the output.
- Input FSM:
  - IN_DATA: on complete-DATA and count<DEPTH, push the decision word, set ack=1, go to IN_NULL.
  - If count==DEPTH, hold with ack=0.
  - IN_NULL: on complete-NULL, set ack=0, go to IN_DATA.
- Output FSM:
  - OUT_NULL (rw=0): if count>0 and ack_in==0, load rw from the FIFO head, go to OUT_DATA.
  - OUT_DATA: hold rw. On ack_in==1, pop, set rw=0, go to OUT_NULL.
- Illegal: any pair 11 in either state sets err=1 at the next edge. No push, FSM state held. err clears only on reset.
- Push and pop in the same cycle: count unchanged, both take effect.
- Full check uses registered count. A pop in the same cycle does not unblock a push until the next edge.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (async, immediate): ack=0, rw=all 0 (NULL), err=0, count=0, pointers 0, IN_DATA, OUT_NULL.
- Reset mid-operation discards all buffered tokens.
- Input complete-DATA sampled at edge k:
  - ack=1 and count+1 after edge k.
  - With the FIFO empty before the push and ack_in=0, rw DATA appears after edge k+1 (1-cycle latency).
- ack falls one edge after complete-NULL is sampled.
- ack_in=1 sampled at edge m in OUT_DATA: rw=NULL and count−1 after edge m.
- Next rw DATA appears no earlier than the edge after ack_in is sampled 0.
- Inputs are assumed glitch-free at edges (synchronous environment). No combinational path from inputs to outputs; all outputs are registered.

## Test plan
- Reset with ph0=mi=8'hAA applied: rw=0, ack=0, count=0, err=0. Release: rw=0 until the first ack_in=0 cycle after a push.
- CH=4, ph0=8'hAA (all true), mi=8'h99 (ch0 false, ch1 true, ch2 false, ch3 true), ack_in=0:
  - ack=1 one cycle later, count=1.
  - rw=8'h99 the next cycle.
  - ack_in=1 → rw=0, count=0.
- Backpressure, ack_in held 1:
  - Four wavefronts give count=4.
  - A fifth DATA is not acked (ack stays 0) until ack_in goes 0 then 1, popping one entry; ack then rises one cycle later.
- Partial wavefront: ph0=8'hAA, mi=8'h29 (ch3 NULL) → ack stays 0, count 0. Set mi=8'h69 → ack=1 next edge.
- Illegal: mi=8'hAB (ch0=11) → err=1 after one edge, count unchanged. err stays 1 after legal traffic resumes, and clears only after rst_n pulse.
- Reset mid-operation: count=2, rw DATA, ack=1. Assert rst_n=0 between edges → rw=0, ack=0, count=0 immediately.

Source files
------------

// File: rtl/mem_rw_mux_sync.sv
// Dual-rail memory read/write select stage. Decodes CH dual-rail (ph0, mi) channel pairs
// into a per-channel RW decision, buffers it in a FIFO and replays it downstream four-phase.
module mem_rw_mux_sync #(
  parameter int unsigned CH    = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [2*CH-1:0]              ph0,
  input  logic [2*CH-1:0]              mi,
  output logic                         ack,
  output logic [2*CH-1:0]              rw,
  input  logic                         ack_in,
  output logic                         err,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] CntFull = CntW'(DEPTH);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);

  typedef enum logic [0:0] {StInData, StInNull}   in_state_e;
  typedef enum logic [0:0] {StOutNull, StOutData} out_state_e;

  in_state_e        in_state_q, in_state_d;
  out_state_e       out_state_q, out_state_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;
  logic [2*CH-1:0]  rw_q, rw_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CH-1:0]    mem_q [DEPTH];

  logic             any_illegal;
  logic             all_data;
  logic             all_null;
  logic [CH-1:0]    word;
  logic [CH-1:0]    head;
  logic [2*CH-1:0]  head_enc;
  logic             push;
  logic             pop;

  // Wavefront classification and per-channel decision (1 = write).
  always_comb begin
    any_illegal = 1'b0;
    all_data    = 1'b1;
    all_null    = 1'b1;
    word        = '0;
    for (int i = 0; i < CH; i++) begin
      if ((ph0[2*i+1] && ph0[2*i]) || (mi[2*i+1] && mi[2*i])) begin
        any_illegal = 1'b1;
      end
      if (!(ph0[2*i+1] ^ ph0[2*i]) || !(mi[2*i+1] ^ mi[2*i])) begin
        all_data = 1'b0;
      end
      if (ph0[2*i+1] || ph0[2*i] || mi[2*i+1] || mi[2*i]) begin
        all_null = 1'b0;
      end
      word[i] = ph0[2*i+1] & mi[2*i+1];
    end
  end

  // Head entry re-encoded to dual rail: true rail = write, false rail = read.
  always_comb begin
    head     = mem_q[rd_ptr_q];
    head_enc = '0;
    for (int i = 0; i < CH; i++) begin
      head_enc[2*i+1] = head[i];
      head_enc[2*i]   = ~head[i];
    end
  end

  // Input handshake FSM; an illegal code freezes it for that cycle.
  always_comb begin
    in_state_d = in_state_q;
    ack_d      = ack_q;
    push       = 1'b0;
    err_d      = err_q | any_illegal;
    if (!any_illegal) begin
      unique case (in_state_q)
        StInData: begin
          // Full check uses the registered count; a same-cycle pop does not help.
          if (all_data && (count_q < CntFull)) begin
            push       = 1'b1;
            ack_d      = 1'b1;
            in_state_d = StInNull;
          end
        end
        StInNull: begin
          if (all_null) begin
            ack_d      = 1'b0;
            in_state_d = StInData;
          end
        end
        default: in_state_d = StInData;
      endcase
    end
  end

  // Output handshake FSM; the displayed entry stays counted until acknowledged.
  always_comb begin
    out_state_d = out_state_q;
    rw_d        = rw_q;
    pop         = 1'b0;
    unique case (out_state_q)
      StOutNull: begin
        if ((count_q != '0) && !ack_in) begin
          rw_d        = head_enc;
          out_state_d = StOutData;
        end
      end
      StOutData: begin
        if (ack_in) begin
          pop         = 1'b1;
          rw_d        = '0;
          out_state_d = StOutNull;
        end
      end
      default: out_state_d = StOutNull;
    endcase
  end

  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PtrOne) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PtrOne) : rd_ptr_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CntOne;
      2'b01:   count_d = count_q - CntOne;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_state_q  <= StInData;
      out_state_q <= StOutNull;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      rw_q        <= '0;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
    end else begin
      in_state_q  <= in_state_d;
      out_state_q <= out_state_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      rw_q        <= rw_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

  assign ack   = ack_q;
  assign rw    = rw_q;
  assign err   = err_q;
  assign count = count_q;

endmodule

// File: tb/tb_mem_rw_mux_sync.sv
// Directed self-checking bench for mem_rw_mux_sync (CH=4, DEPTH=4).
module tb_mem_rw_mux_sync;

  logic       clk;
  logic       rst_n;
  logic [7:0] ph0;
  logic [7:0] mi;
  logic       ack;
  logic [7:0] rw;
  logic       ack_in;
  logic       err;
  logic [2:0] count;

  int n_cmp;
  int n_fail;

  mem_rw_mux_sync #(
    .CH   (4),
    .DEPTH(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ph0   (ph0),
    .mi    (mi),
    .ack   (ack),
    .rw    (rw),
    .ack_in(ack_in),
    .err   (err),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    ph0    = 8'hAA;
    mi     = 8'hAA;
    ack_in = 1'b0;
    #2;
    n_cmp++; if (rw !== 8'h00) begin n_fail++; $display("FAIL reset_rw got=%h exp=00", rw); end
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack got=%b exp=0", ack); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%b exp=0", err); end
    step();
    n_cmp++; if (rw !== 8'h00) begin n_fail++; $display("FAIL reset_hold_rw got=%h exp=00", rw); end
    ph0   = 8'h00;
    mi    = 8'h00;
    rst_n = 1'b1;
    step();
    step();
    n_cmp++; if (rw !== 8'h00) begin n_fail++; $display("FAIL release_rw got=%h exp=00", rw); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL release_count got=%0d exp=0", count); end
  endtask

  task automatic test_basic();
    ph0    = 8'hAA;
    mi     = 8'h99;
    ack_in = 1'b0;
    step();
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL basic_ack got=%b exp=1", ack); end
    n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL basic_count got=%0d exp=1", count); end
    n_cmp++; if (rw !== 8'h00) begin n_fail++; $display("FAIL basic_rw_early got=%h exp=00", rw); end
    step();
    n_cmp++; if (rw !== 8'h99) begin n_fail++; $display("FAIL basic_rw got=%h exp=99", rw); end
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL basic_ack_hold got=%b exp=1", ack); end
    ph0 = 8'h00;
    mi  = 8'h00;
    step();
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL basic_ack_fall got=%b exp=0", ack); end
    n_cmp++; if (rw !== 8'h99) begin n_fail++; $display("FAIL basic_rw_hold got=%h exp=99", rw); end
    ack_in = 1'b1;
    step();
    n_cmp++; if (rw !== 8'h00) begin n_fail++; $display("FAIL basic_rw_null got=%h exp=00", rw); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL basic_count_pop got=%0d exp=0", count); end
    ack_in = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic [7:0] vp [4];
    logic [7:0] vm [4];
    logic [7:0] exp_rw [4];
    vp = '{8'hAA, 8'h55, 8'hAA, 8'h66};
    vm = '{8'hAA, 8'hAA, 8'h55, 8'hAA};
    exp_rw = '{8'h55, 8'h55, 8'h66, 8'hAA};
    ack_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ph0 = vp[i];
      mi  = vm[i];
      step();
      n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL b2b_ack[%0d] got=%b exp=1", i, ack); end
      ph0 = 8'h00;
      mi  = 8'h00;
      step();
      n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL b2b_nack[%0d] got=%b exp=0", i, ack); end
    end
    n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL b2b_full got=%0d exp=4", count); end
    n_cmp++; if (rw !== 8'h00) begin n_fail++; $display("FAIL b2b_rw_blocked got=%h exp=00", rw); end
    ph0 = 8'hAA;
    mi  = 8'hAA;
    step();
    step();
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL full_no_ack got=%b exp=0", ack); end
    n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count got=%0d exp=4", count); end
    ack_in = 1'b0;
    step();
    n_cmp++; if (rw !== 8'hAA) begin n_fail++; $display("FAIL full_head_rw got=%h exp=aa", rw); end
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL full_ack_still0 got=%b exp=0", ack); end
    ack_in = 1'b1;
    step();
    n_cmp++; if (count !== 3'd3) begin n_fail++; $display("FAIL full_pop_count got=%0d exp=3", count); end
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL full_pop_same_edge got=%b exp=0", ack); end
    step();
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL full_unblock_ack got=%b exp=1", ack); end
    n_cmp++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_refill got=%0d exp=4", count); end
    ph0 = 8'h00;
    mi  = 8'h00;
    step();
    // Drain remaining entries in order.
    for (int i = 0; i < 4; i++) begin
      ack_in = 1'b0;
      step();
      n_cmp++;
      if (rw !== exp_rw[i]) begin
        n_fail++; $display("FAIL drain_rw[%0d] got=%h exp=%h", i, rw, exp_rw[i]);
      end
      ack_in = 1'b1;
      step();
      n_cmp++;
      if (count !== 3'(3 - i)) begin
        n_fail++; $display("FAIL drain_count[%0d] got=%0d exp=%0d", i, count, 3 - i);
      end
    end
    n_cmp++; if (rw !== 8'h00) begin n_fail++; $display("FAIL drain_rw_null got=%h exp=00", rw); end
    ack_in = 1'b0;
    step();
  endtask

  task automatic test_partial();
    ph0 = 8'hAA;
    mi  = 8'h29;
    step();
    step();
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL partial_ack got=%b exp=0", ack); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL partial_count got=%0d exp=0", count); end
    mi = 8'h69;
    step();
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL partial_done_ack got=%b exp=1", ack); end
    n_cmp++; if (count !== 3'd1) begin n_fail++; $display("FAIL partial_done_count got=%0d exp=1", count); end
    step();
    n_cmp++; if (rw !== 8'h69) begin n_fail++; $display("FAIL partial_rw got=%h exp=69", rw); end
    ph0    = 8'h00;
    mi     = 8'h00;
    ack_in = 1'b1;
    step();
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL partial_ack_fall got=%b exp=0", ack); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL partial_pop got=%0d exp=0", count); end
    ack_in = 1'b0;
    step();
  endtask

  task automatic test_illegal();
    ph0 = 8'hAA;
    mi  = 8'hAB;
    step();
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_err got=%b exp=1", err); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL illegal_count got=%0d exp=0", count); end
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL illegal_ack got=%b exp=0", ack); end
    mi = 8'hAA;
    step();
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL illegal_resume_ack got=%b exp=1", ack); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky got=%b exp=1", err); end
    ph0 = 8'h00;
    mi  = 8'h00;
    step();
    n_cmp++; if (rw !== 8'hAA) begin n_fail++; $display("FAIL illegal_resume_rw got=%h exp=aa", rw); end
    ack_in = 1'b1;
    step();
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky2 got=%b exp=1", err); end
    ack_in = 1'b0;
    rst_n  = 1'b0;
    #1;
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL illegal_clear got=%b exp=0", err); end
    #1;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset_mid();
    ph0 = 8'h55;
    mi  = 8'h55;
    step();
    ph0 = 8'h00;
    mi  = 8'h00;
    step();
    ph0 = 8'hAA;
    mi  = 8'hAA;
    step();
    n_cmp++; if (count !== 3'd2) begin n_fail++; $display("FAIL mid_pre_count got=%0d exp=2", count); end
    n_cmp++; if (rw !== 8'h55) begin n_fail++; $display("FAIL mid_pre_rw got=%h exp=55", rw); end
    n_cmp++; if (ack !== 1'b1) begin n_fail++; $display("FAIL mid_pre_ack got=%b exp=1", ack); end
    rst_n = 1'b0;
    #1;
    n_cmp++; if (rw !== 8'h00) begin n_fail++; $display("FAIL mid_rw got=%h exp=00", rw); end
    n_cmp++; if (ack !== 1'b0) begin n_fail++; $display("FAIL mid_ack got=%b exp=0", ack); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid_count got=%0d exp=0", count); end
    ph0 = 8'h00;
    mi  = 8'h00;
    #1;
    rst_n = 1'b1;
    step();
    step();
    n_cmp++; if (rw !== 8'h00) begin n_fail++; $display("FAIL mid_discard_rw got=%h exp=00", rw); end
    n_cmp++; if (count !== 3'd0) begin n_fail++; $display("FAIL mid_discard_count got=%0d exp=0", count); end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_partial();
    test_illegal();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
